// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states,
// prefix codes, frame geometry and the frame validity check.
package ps2_keyboard_receiver_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE    = 2'd0,
    PS2_RECEIVE = 2'd1,
    PS2_CHECK   = 2'd2
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  // Start bit low, stop bit high, odd parity over data+parity bits.
  function automatic logic frameValid(input logic [PS2_FRAME_BITS-1:0] frame);
    return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
  endfunction

  // Data byte sits between the start bit and the parity bit.
  function automatic logic [7:0] frameCode(input logic [PS2_FRAME_BITS-1:0] frame);
    return frame[8:1];
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_line_synchronizer.sv
// Two-flop synchronizer for an asynchronous PS/2 line, plus a registered
// one-cycle falling-edge strobe. Flops reset to the idle-high line level.
module ps2_line_synchronizer (
  input  logic Clock,
  input  logic Reset,
  input  logic iLine,
  output logic oSync,
  output logic oFall
);

  logic [1:0] syncReg;
  logic       prevReg;

  // Synchronize, remember the previous synced level, register the fall strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncReg <= 2'b11;
      prevReg <= 1'b1;
      oFall   <= 1'b0;
    end else begin
      syncReg <= {syncReg[0], iLine};
      prevReg <= syncReg[1];
      oFall   <= prevReg & ~syncReg[1];
    end
  end

  assign oSync = syncReg[1];

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: deframes 11-bit frames, validates them, folds the
// E0/F0 prefixes into flags and presents one event per key action through a
// ready/acknowledge holding register.
module ps2_keyboard_receiver
  import ps2_keyboard_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_Clock,
  input  logic       iPS2_Data,
  output logic [7:0] oScanCode,
  output logic       oExtended,
  output logic       oBreak,
  output logic       oDataReady,
  input  logic       iDataReceived,
  output logic       oFrameError,
  output logic       oOverrun
);

  logic                      ps2Fall;
  logic                      ps2ClockSync;
  logic [1:0]                dataSyncReg;
  logic                      dataSync;
  ps2_state_t                state;
  logic [3:0]                bitCount;
  logic [PS2_FRAME_BITS-1:0] shiftReg;
  logic [TIMEOUT_WIDTH-1:0]  timeoutCnt;
  logic                      extPending;
  logic                      brkPending;
  logic                      holdFree;

  ps2_line_synchronizer uClockSync (
    .Clock (Clock),
    .Reset (Reset),
    .iLine (iPS2_Clock),
    .oSync (ps2ClockSync),
    .oFall (ps2Fall)
  );

  // Data line needs only the synchronized level, no edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) dataSyncReg <= 2'b11;
    else       dataSyncReg <= {dataSyncReg[0], iPS2_Data};
  end

  assign dataSync = dataSyncReg[1];

  // Holding register can take a new code if empty or being acknowledged now.
  assign holdFree = ~oDataReady | iDataReceived;

  // Frame FSM, timeout, prefix tracking and the output holding register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= PS2_IDLE;
      bitCount    <= 4'd0;
      shiftReg    <= '0;
      timeoutCnt  <= '0;
      extPending  <= 1'b0;
      brkPending  <= 1'b0;
      oScanCode   <= 8'h00;
      oExtended   <= 1'b0;
      oBreak      <= 1'b0;
      oDataReady  <= 1'b0;
      oFrameError <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      oFrameError <= 1'b0;
      oOverrun    <= 1'b0;
      if (oDataReady && iDataReceived) oDataReady <= 1'b0;

      case (state)
        PS2_IDLE: begin
          timeoutCnt <= '0;
          if (ps2Fall) begin
            shiftReg <= {dataSync, shiftReg[PS2_FRAME_BITS-1:1]};
            bitCount <= 4'd1;
            state    <= PS2_RECEIVE;
          end
        end

        PS2_RECEIVE: begin
          if (ps2Fall) begin
            shiftReg   <= {dataSync, shiftReg[PS2_FRAME_BITS-1:1]};
            bitCount   <= bitCount + 4'd1;
            timeoutCnt <= '0;
            if (bitCount == 4'(PS2_FRAME_BITS - 1)) state <= PS2_CHECK;
          end else if (timeoutCnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
            // Keyboard stalled mid-frame: discard the partial frame.
            oFrameError <= 1'b1;
            bitCount    <= 4'd0;
            timeoutCnt  <= '0;
            extPending  <= 1'b0;
            brkPending  <= 1'b0;
            state       <= PS2_IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + TIMEOUT_WIDTH'(1);
          end
        end

        PS2_CHECK: begin
          state    <= PS2_IDLE;
          bitCount <= 4'd0;
          if (!frameValid(shiftReg)) begin
            // A corrupt frame may have been the code a prefix belonged to.
            oFrameError <= 1'b1;
            extPending  <= 1'b0;
            brkPending  <= 1'b0;
          end else if (frameCode(shiftReg) == PS2_PREFIX_EXT) begin
            extPending <= 1'b1;
          end else if (frameCode(shiftReg) == PS2_PREFIX_BREAK) begin
            brkPending <= 1'b1;
          end else begin
            extPending <= 1'b0;
            brkPending <= 1'b0;
            if (holdFree) begin
              oScanCode  <= frameCode(shiftReg);
              oExtended  <= extPending;
              oBreak     <= brkPending;
              oDataReady <= 1'b1;
            end else begin
              oOverrun <= 1'b1;
            end
          end
        end

        default: begin
          state    <= PS2_IDLE;
          bitCount <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: frames are bit-banged on the raw
// PS/2 lines and outputs are sampled on falling system-clock edges.
module tb_ps2_keyboard_receiver;

  localparam int TO_CYCLES = 200;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iPS2_Clock = 1'b1;
  logic       iPS2_Data = 1'b1;
  logic [7:0] oScanCode;
  logic       oExtended;
  logic       oBreak;
  logic       oDataReady;
  logic       iDataReceived = 1'b0;
  logic       oFrameError;
  logic       oOverrun;

  int checks = 0;
  int errors = 0;
  int errPulses = 0;
  int ovrPulses = 0;

  // Observations around the 11th bit; index k = sampled after edge N+k-1.
  logic       obsRdy [1:6];
  logic       obsErr [1:6];
  logic       obsOvr [1:6];
  logic [7:0] obsCode;
  logic       obsExt;
  logic       obsBrk;

  ps2_keyboard_receiver #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .TIMEOUT_WIDTH  (17)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iPS2_Clock    (iPS2_Clock),
    .iPS2_Data     (iPS2_Data),
    .oScanCode     (oScanCode),
    .oExtended     (oExtended),
    .oBreak        (oBreak),
    .oDataReady    (oDataReady),
    .iDataReceived (iDataReceived),
    .oFrameError   (oFrameError),
    .oOverrun      (oOverrun)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    #1;
    if (oFrameError) errPulses++;
    if (oOverrun)    ovrPulses++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input logic badPar);
    logic par;
    par = ~^code ^ badPar;
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic driveBit(input logic b);
    @(negedge Clock);
    iPS2_Data = b;
    repeat (4) @(negedge Clock);
    iPS2_Clock = 1'b0;
    repeat (8) @(negedge Clock);
    iPS2_Clock = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  task automatic sendBits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) driveBit(frame[i]);
  endtask

  // Full frame; the 11th bit is held low while outputs are recorded.
  task automatic sendFrame(input logic [7:0] code, input logic badPar, input logic ackInCheck);
    logic [10:0] fr;
    fr = makeFrame(code, badPar);
    sendBits(fr, 10);
    @(negedge Clock);
    iPS2_Data = fr[10];
    repeat (4) @(negedge Clock);
    iPS2_Clock = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      obsRdy[k] = oDataReady;
      obsErr[k] = oFrameError;
      obsOvr[k] = oOverrun;
      if (k == 5) begin
        obsCode = oScanCode;
        obsExt  = oExtended;
        obsBrk  = oBreak;
      end
      if (ackInCheck) iDataReceived = (k == 4);
    end
    iDataReceived = 1'b0;
    iPS2_Clock = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  task automatic ackCode();
    @(negedge Clock);
    iDataReceived = 1'b1;
    @(negedge Clock);
    iDataReceived = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    checks++;
    if ({oScanCode, oExtended, oBreak, oDataReady, oFrameError, oOverrun} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000",
               {oScanCode, oExtended, oBreak, oDataReady, oFrameError, oOverrun});
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_basic();
    int e0;
    e0 = errPulses;
    sendFrame(8'h1C, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[1], obsRdy[2], obsRdy[3], obsRdy[4]} !== 4'b0000) begin
      errors++; $display("FAIL basic_latency_early: got %b want 0000",
                         {obsRdy[1], obsRdy[2], obsRdy[3], obsRdy[4]});
    end
    checks++;
    if (obsRdy[5] !== 1'b1) begin errors++; $display("FAIL basic_ready_n4: got %b want 1", obsRdy[5]); end
    checks++;
    if (obsCode !== 8'h1C) begin errors++; $display("FAIL basic_code: got %h want 1c", obsCode); end
    checks++;
    if ({obsExt, obsBrk} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {obsExt, obsBrk}); end
    checks++;
    if (errPulses !== e0) begin errors++; $display("FAIL basic_no_error: got %0d want %0d", errPulses, e0); end
    ackCode();
    checks++;
    if (oDataReady !== 1'b0) begin errors++; $display("FAIL basic_ack_clears: got %b want 0", oDataReady); end
  endtask

  task automatic test_prefix();
    sendFrame(8'hF0, 1'b0, 1'b0);
    checks++;
    if (obsRdy[5] !== 1'b0) begin errors++; $display("FAIL prefix_f0_not_presented: got %b want 0", obsRdy[5]); end
    sendFrame(8'h1C, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[5], obsCode, obsExt, obsBrk} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
      errors++; $display("FAIL prefix_break_1c: got rdy=%b code=%h ext=%b brk=%b want 1 1c 0 1",
                         obsRdy[5], obsCode, obsExt, obsBrk);
    end
    ackCode();
    sendFrame(8'hE0, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b0);
    sendFrame(8'h75, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[5], obsCode, obsExt, obsBrk} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
      errors++; $display("FAIL prefix_ext_break_75: got rdy=%b code=%h ext=%b brk=%b want 1 75 1 1",
                         obsRdy[5], obsCode, obsExt, obsBrk);
    end
    ackCode();
  endtask

  task automatic test_parity();
    int e0;
    sendFrame(8'hF0, 1'b0, 1'b0);
    e0 = errPulses;
    sendFrame(8'h1C, 1'b1, 1'b0);
    checks++;
    if ({obsErr[4], obsErr[5], obsErr[6]} !== 3'b010) begin
      errors++; $display("FAIL parity_error_pulse: got %b want 010", {obsErr[4], obsErr[5], obsErr[6]});
    end
    checks++;
    if (errPulses !== e0 + 1) begin errors++; $display("FAIL parity_error_count: got %0d want %0d", errPulses, e0 + 1); end
    checks++;
    if (obsRdy[6] !== 1'b0) begin errors++; $display("FAIL parity_no_ready: got %b want 0", obsRdy[6]); end
    sendFrame(8'h1C, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[5], obsCode, obsBrk} !== {1'b1, 8'h1C, 1'b0}) begin
      errors++; $display("FAIL parity_prefix_cleared: got rdy=%b code=%h brk=%b want 1 1c 0",
                         obsRdy[5], obsCode, obsBrk);
    end
    ackCode();
  endtask

  task automatic test_overrun();
    int o0;
    sendFrame(8'h1C, 1'b0, 1'b0);
    o0 = ovrPulses;
    sendFrame(8'h32, 1'b0, 1'b0);
    checks++;
    if ({obsOvr[4], obsOvr[5], obsOvr[6]} !== 3'b010) begin
      errors++; $display("FAIL overrun_pulse: got %b want 010", {obsOvr[4], obsOvr[5], obsOvr[6]});
    end
    checks++;
    if (ovrPulses !== o0 + 1) begin errors++; $display("FAIL overrun_count: got %0d want %0d", ovrPulses, o0 + 1); end
    checks++;
    if ({obsRdy[5], obsCode} !== {1'b1, 8'h1C}) begin
      errors++; $display("FAIL overrun_keeps_old: got rdy=%b code=%h want 1 1c", obsRdy[5], obsCode);
    end
    o0 = ovrPulses;
    sendFrame(8'h32, 1'b0, 1'b1);
    checks++;
    if ({obsRdy[5], obsRdy[6], obsCode} !== {1'b1, 1'b1, 8'h32}) begin
      errors++; $display("FAIL ack_in_check_loads: got rdy=%b%b code=%h want 11 32", obsRdy[5], obsRdy[6], obsCode);
    end
    checks++;
    if (ovrPulses !== o0) begin errors++; $display("FAIL ack_in_check_no_overrun: got %0d want %0d", ovrPulses, o0); end
    ackCode();
  endtask

  task automatic test_timeout();
    int e0;
    int waited;
    e0 = errPulses;
    sendBits(makeFrame(8'hAA, 1'b0), 5);
    waited = 0;
    while (errPulses == e0 && waited < 3 * TO_CYCLES) begin
      @(negedge Clock);
      waited++;
    end
    checks++;
    if (errPulses !== e0 + 1) begin errors++; $display("FAIL timeout_error: got %0d pulses want %0d", errPulses, e0 + 1); end
    checks++;
    if (oDataReady !== 1'b0) begin errors++; $display("FAIL timeout_no_ready: got %b want 0", oDataReady); end
    e0 = errPulses;
    sendFrame(8'h29, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[5], obsCode, obsExt, obsBrk} !== {1'b1, 8'h29, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_next_frame: got rdy=%b code=%h ext=%b brk=%b want 1 29 0 0",
                         obsRdy[5], obsCode, obsExt, obsBrk);
    end
    checks++;
    if (errPulses !== e0) begin errors++; $display("FAIL timeout_next_no_error: got %0d want %0d", errPulses, e0); end
    ackCode();
  endtask

  task automatic test_reset_midframe();
    int e0;
    sendFrame(8'h1C, 1'b0, 1'b0);
    sendFrame(8'hF0, 1'b0, 1'b0);
    sendBits(makeFrame(8'h55, 1'b0), 6);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if ({oScanCode, oExtended, oBreak, oDataReady, oFrameError, oOverrun} !== 13'h0) begin
      errors++; $display("FAIL midframe_reset_outputs: got %h want 0000",
                         {oScanCode, oExtended, oBreak, oDataReady, oFrameError, oOverrun});
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    e0 = errPulses;
    sendFrame(8'h1C, 1'b0, 1'b0);
    checks++;
    if ({obsRdy[5], obsCode, obsExt, obsBrk} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midframe_reset_next: got rdy=%b code=%h ext=%b brk=%b want 1 1c 0 0",
                         obsRdy[5], obsCode, obsExt, obsBrk);
    end
    checks++;
    if (errPulses !== e0) begin errors++; $display("FAIL midframe_reset_no_error: got %0d want %0d", errPulses, e0); end
    ackCode();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_overrun();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_receiver.md
# ps2_keyboard_receiver

Receives PS/2 keyboard frames on the system clock and presents decoded scan codes to the MiniAlu instruction datapath through a ready/acknowledge handshake. It samples the asynchronous keyboard clock and data lines, deframes 11-bit frames, and checks the start, stop and parity bits. It also folds the E0 (extended) and F0 (break) prefixes into flags, so the processor sees one event per key action.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: idle Clock cycles inside a frame before the partial frame is discarded (2 ms at 50 MHz).
- TIMEOUT_WIDTH, 17: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- Clock  in  1  system clock, 50 MHz; one clock, all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- iPS2_Clock  in  1  raw keyboard clock, asynchronous, idles high.
- iPS2_Data  in  1  raw keyboard data, asynchronous, idles high.
- oScanCode  out  8  presented scan code; stable while oDataReady=1.
- oExtended  out  1  code was preceded by E0.
- oBreak  out  1  code was preceded by F0 (key release).
- oDataReady  out  1  a code is held and waiting for acknowledge.
- iDataReceived  in  1  consumer acknowledge.
- oFrameError  out  1  one-cycle pulse: bad start, stop or parity bit, or timeout.
- oOverrun  out  1  one-cycle pulse: a valid code was dropped because the holding register was full.

## Operation
- Synchronizers: iPS2_Clock and iPS2_Data each pass through 2 flops, which reset to 1. A third flop on the clock line produces fall = prev & ~sync.
- States:
  - IDLE: waits for fall. On fall, shifts in bit 0 and goes to RECEIVE with bit count 1.
  - RECEIVE: each fall shifts the synced data into an 11-bit LSB-first register and increments the count. When the count reaches 11, goes to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE.
- Frame valid when: bit0 = 0, bit10 = 1, and XOR of bits[9:1] = 1 (odd parity).
- Timeout: the counter clears on every fall and increments in RECEIVE. When it reaches TIMEOUT_CYCLES, the block pulses oFrameError, clears the bit count and prefix flags, and returns to IDLE.
- CHECK, invalid frame: pulse oFrameError, clear prefix flags, outputs otherwise unchanged.
- CHECK, valid code E0: set ext_pending; nothing presented.
- CHECK, valid code F0: set brk_pending; nothing presented.
- CHECK, any other valid code:
  - If the holding register is free (oDataReady=0, or iDataReceived=1 this cycle): load oScanCode, set oExtended = ext_pending and oBreak = brk_pending, set oDataReady, clear the pending flags.
  - Otherwise: pulse oOverrun, drop the code, clear the pending flags.
- Handshake: oDataReady stays 1 until a cycle with iDataReceived=1. It is 0 from the next edge unless a new code loads in that same cycle, in which case it stays 1 with the new code. iDataReceived while oDataReady=0 is ignored.
- Reset (any time, including mid-frame):
  - state IDLE, count 0, prefix flags 0;
  - oScanCode = 0, oExtended = 0, oBreak = 0, oDataReady = 0, oFrameError = 0, oOverrun = 0;
  - synchronizer flops = 1.

## Timing
- Raw clock sampled low at edge N gives fall high after edge N+2. The bit is shifted at edge N+3.
- For the 11th bit, state is CHECK after edge N+3 and outputs update at edge N+4. Latency from the 11th raw falling sample to oDataReady is 4 Clock cycles.
- oFrameError and oOverrun are high for exactly one cycle, registered, at the same edge where outputs would have loaded.
- Throughput: at most one code per PS/2 frame (about 1 ms). The consumer must acknowledge within one frame time to avoid overrun.

## Structure
- The shared definitions file holds:
  - state encodings: PS2_IDLE=2'd0, PS2_RECEIVE=2'd1, PS2_CHECK=2'd2;
  - PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BREAK = 8'hF0;
  - PS2_FRAME_BITS = 11.
- One sub-module: ps2_line_synchronizer, a 2-flop synchronizer with falling-edge output. It is instantiated for the clock line; the data line uses its synchronized output only.

## Test plan
- Frame 0x1C (data 00111000 LSB-first, parity 0) -> oScanCode=1C, oDataReady=1, oExtended=0, oBreak=0, 4 cycles after the 11th falling edge. Pulse iDataReceived -> oDataReady=0 next cycle.
- Frames F0, 1C -> only one presentation: oScanCode=1C, oBreak=1. Then E0, F0, 75 -> oScanCode=75, oExtended=1, oBreak=1.
- Frame 0x1C with parity bit 1 -> oFrameError pulses 1 cycle, oDataReady stays 0. A following F0-free 0x1C -> oBreak=0.
- Frames 0x1C then 0x32 with no acknowledge -> oScanCode stays 1C, oOverrun pulses once. With iDataReceived asserted in the CHECK cycle of 0x32 -> oScanCode=32, oDataReady stays 1, no oOverrun.
- Timeout: 5 bits, then 100000 idle cycles -> oFrameError pulse. A following full frame 0x29 -> oScanCode=29, received correctly.
- Reset asserted after 6 bits -> all outputs 0. A following full frame 0x1C decodes correctly with no error pulse.
